keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clocks per row dwell (1 ms at 50 MHz); legal values are 4 or greater.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 20: consecutive matching row ticks required to accept a press or a release; legal values are 1 or greater.
REQ-003 SHALL have port clock, input, 1 bit: the single clock (MAX10_CLK1_50); all state is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (KEY0).
REQ-005 SHALL have port keypadCol, input, 4 bits: keypad columns, active-low, asynchronous to clock.
REQ-006 SHALL have port keypadRow, output, 4 bits: keypad row drive, one-cold (exactly one bit low at all times).
REQ-007 SHALL have port key_code, output, 4 bits: accepted key, equal to row_idx*4+col_idx.
REQ-008 SHALL have port key_valid, output, 1 bit: one-cycle pulse when a new key is accepted.
REQ-009 SHALL have port key_held, output, 1 bit: high from acceptance until release is accepted.

Function
REQ-010 SHALL pass keypadCol through a 2-flop synchronizer; all logic below uses the synchronized value col_s.
REQ-011 SHALL run a dwell counter that wraps at SCAN_DIV-1 and generates tick on its terminal cycle; the counter runs in every state.
REQ-012 SHALL classify col_s as: none = 4'b1111; single = exactly one bit low; multi = two or more bits low. Multi is treated as not-single (ghost rejection).
REQ-013 SHALL implement FSM states SCAN, DEBOUNCE and HELD, with one-hot or binary encoding left free.
REQ-014 In SCAN, on tick: if single, capture row_idx and col_idx (position of the low bit), clear stab_cnt, and go to DEBOUNCE with the row frozen; otherwise advance row_idx modulo 4 (3 wraps to 0).
REQ-015 In DEBOUNCE, on tick: if col_s equals the captured column pattern, increment stab_cnt; if the incremented value equals DEBOUNCE_CNT, go to HELD; on a mismatch (none, multi, or a different column), go to SCAN and advance row_idx.
REQ-016 On the DEBOUNCE to HELD transition, key_code SHALL load {row_idx, col_idx} and key_valid SHALL be high for exactly the next clock cycle, coincident with the new key_code.
REQ-017 In HELD, the row SHALL stay frozen, and on tick: if none, increment rel_cnt; otherwise clear rel_cnt. When rel_cnt reaches DEBOUNCE_CNT, go to SCAN, advance row_idx and drop key_held in the same cycle.
REQ-018 key_code SHALL hold its value between acceptances; key_valid SHALL never assert in SCAN or while already in HELD.
REQ-019 Pressing a second key while in HELD SHALL produce no key_valid; the new key is accepted only after release completes and a fresh SCAN detects it.
REQ-020 keypadRow SHALL equal ~(4'b0001 << row_idx), registered, and change only on tick boundaries.
REQ-021 stab_cnt and rel_cnt SHALL be sized to hold DEBOUNCE_CNT and SHALL saturate, never wrap.

Reset
REQ-022 While reset is low, the block SHALL force state=SCAN, row_idx=0, keypadRow=4'b1110, key_code=0, key_valid=0, key_held=0, all counters=0 and synchronizer=4'b1111.
REQ-023 Reset asserted mid-DEBOUNCE or mid-HELD SHALL abort immediately with no key_valid pulse; after release, scanning restarts at row 0 with a full dwell.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-024 Reset, no press -> keypadRow cycles 1110, 1101, 1011, 0111, 1110, each held 4 clocks; key_valid stays 0.
REQ-025 Hold col=4'b1101 only while row 2 is low, then keep it stable -> row freezes at 1011; after 3 more ticks key_valid pulses once with key_code=9 and key_held=1.
REQ-026 Bounce: col goes low for 1 tick during DEBOUNCE, then releases -> no key_valid; scanning resumes at the next row.
REQ-027 Press col=4'b1100 (two columns) -> treated as no press; no capture, rows keep rotating.
REQ-028 Accept key 5, release for 2 ticks, re-press, then release for 3 ticks -> exactly one key_valid; key_held falls after the 3rd release tick.
REQ-029 Assert reset in HELD with key 15 -> outputs return to reset values immediately; key_code=0 and no spurious pulse after release.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronized active-low columns,
// ghost rejection, press/release debounce and a one-cycle key_valid strobe.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_s;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_state;
  logic [1:0]       r_row_idx;
  logic [1:0]       r_col_idx;
  logic [3:0]       r_col_pat;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [CNT_W-1:0] r_rel_cnt;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;
  logic [3:0]       r_row_drive;

  logic             w_tick;
  logic [3:0]       w_col_low;
  logic             w_none;
  logic             w_single;
  logic [1:0]       w_col_pos;
  logic [1:0]       w_row_inc;
  logic [3:0]       w_row_inc_drive;
  logic [CNT_W-1:0] w_stab_inc;
  logic [CNT_W-1:0] w_rel_inc;

  // NOTE: every register, including the synchronizer, has an async reset value so
  // the block never leaves reset holding a stale column sample or a half-accepted key.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col_meta <= 4'hF;
      r_col_s    <= 4'hF;
      r_div      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value.
      r_col_meta <= keypadCol;
      r_col_s    <= r_col_meta;
      r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  assign w_tick    = (r_div == DIV_LAST);
  assign w_col_low = ~r_col_s;
  assign w_none    = (r_col_s == 4'hF);
  // Exactly one low column: non-zero and a power of two; anything else is a ghost.
  assign w_single  = !w_none && ((w_col_low & (w_col_low - 4'd1)) == 4'd0);

  assign w_row_inc       = r_row_idx + 2'd1;
  assign w_row_inc_drive = ~(4'b0001 << w_row_inc);
  assign w_stab_inc      = (r_stab_cnt == CNT_MAX) ? CNT_MAX : r_stab_cnt + CNT_W'(1);
  assign w_rel_inc       = (r_rel_cnt == CNT_MAX) ? CNT_MAX : r_rel_cnt + CNT_W'(1);

  // NOTE: a default assignment ahead of the case prevents an inferred latch.
  always_comb begin
    w_col_pos = 2'd0;
    case (w_col_low)
      4'b0010: w_col_pos = 2'd1;
      4'b0100: w_col_pos = 2'd2;
      4'b1000: w_col_pos = 2'd3;
      default: w_col_pos = 2'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_col_idx   <= 2'd0;
      r_col_pat   <= 4'hF;
      r_stab_cnt  <= '0;
      r_rel_cnt   <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_row_drive <= 4'b1110;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_single) begin
              r_col_idx  <= w_col_pos;
              r_col_pat  <= r_col_s;
              r_stab_cnt <= '0;
              r_state    <= ST_DEBOUNCE;
            end else begin
              r_row_idx   <= w_row_inc;
              r_row_drive <= w_row_inc_drive;
            end
          end
          ST_DEBOUNCE: begin
            if (r_col_s == r_col_pat) begin
              r_stab_cnt <= w_stab_inc;
              if (w_stab_inc == CNT_MAX) begin
                r_state     <= ST_HELD;
                r_rel_cnt   <= '0;
                r_key_code  <= {r_row_idx, r_col_idx};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
            end else begin
              r_state     <= ST_SCAN;
              r_row_idx   <= w_row_inc;
              r_row_drive <= w_row_inc_drive;
            end
          end
          ST_HELD: begin
            if (w_none) begin
              r_rel_cnt <= w_rel_inc;
              if (w_rel_inc == CNT_MAX) begin
                r_state     <= ST_SCAN;
                r_key_held  <= 1'b0;
                r_row_idx   <= w_row_inc;
                r_row_drive <= w_row_inc_drive;
              end
            end else begin
              r_rel_cnt <= '0;
            end
          end
          default: r_state <= ST_SCAN;
        endcase
      end
    end
  end

  assign keypadRow = r_row_drive;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
